conc_trace_capture: RTL

Response-side counterpart to the stimulus sequencer: records DUT observation samples into a trace buffer and streams them back out. Each cycle that `obs` is high during a recording window, the block stores the current program counter with the DUT output word. The stored entries are later drained through a valid/ready read port. It sits beside the DUT in the concolic harness and closes the loop between applied opcodes and the responses they produce.

---
 rtl/conc_trace_pkg.sv | 26 ++
 rtl/conc_trace_fifo.sv | 64 ++++++
 rtl/conc_trace_capture.sv | 123 ++++++++++++
 3 files changed

// File: rtl/conc_trace_pkg.sv
// conc_trace_pkg: shared types and width helpers for the trace-capture block.
//   state_e     - capture FSM states (IDLE, RECORD, DRAIN)
//   ENTRY_W_DEF - entry width for the default PC_W/DATA_W
//   entry_w()   - entry width helper, {pc, dut_out}
//   cnt_w()     - width of an occupancy counter able to hold DEPTH
package conc_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned DATA_W_DEF  = 128;
  localparam int unsigned ENTRY_W_DEF = PC_W_DEF + DATA_W_DEF;

  function automatic int unsigned entry_w(input int unsigned pc_w, input int unsigned data_w);
    return pc_w + data_w;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/conc_trace_fifo.sv
// conc_trace_fifo: first-word fall-through trace storage.
// Ports:
//   clk, rst      - clock, async active-low reset
//   clr           - synchronous clear of pointers and count
//   push, pop     - write / read strobes (caller guarantees legality)
//   wdata         - entry to store
//   rdata         - oldest entry, zero when empty
//   count         - number of entries held
//   full          - count == DEPTH
module conc_trace_fifo
  import conc_trace_pkg::*;
#(
  parameter int WIDTH = 160,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  // On push+pop while full, wr_ptr == rd_ptr: the head is read out this
  // cycle before the slot is overwritten at the edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/conc_trace_capture.sv
// conc_trace_capture: records {pc, dut_out} samples during a recording
// window and streams them out through a valid/ready read port.
// Ports:
//   clk, rst           - clock, async active-low reset
//   arm, stop          - open / close the recording window
//   obs, pc, dut_out   - sample strobe, pc tag, DUT response word
//   rd_valid, rd_ready - read handshake; rd_data = head entry {pc, dut_out}
//   count              - entries held
//   overflow           - sticky: a sample was dropped on a full buffer
//   busy, done         - not-IDLE flag, one-cycle pulse on DRAIN->IDLE
// Build option: CONC_TRACE_DEDUP_EN drops samples whose dut_out repeats the
// last accepted dut_out of the current window.
//
// state  | meaning
// IDLE   | waiting for arm; obs ignored
// RECORD | pushing obs samples, popping allowed
// DRAIN  | popping only; leaves when count reaches 0
module conc_trace_capture
  import conc_trace_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            arm,
  input  logic                            stop,
  input  logic                            obs,
  input  logic [PC_W-1:0]                 pc,
  input  logic [DATA_W-1:0]               dut_out,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [entry_w(PC_W,DATA_W)-1:0] rd_data,
  output logic [cnt_w(DEPTH)-1:0]         count,
  output logic                            overflow,
  output logic                            busy,
  output logic                            done
);

  state_e state;
  logic   clr;
  logic   pop;
  logic   dup;
  logic   push_req;
  logic   push;
  logic   full;

  assign clr      = (state == ST_IDLE) && arm;
  assign rd_valid = (count != '0);
  assign pop      = rd_valid && rd_ready && (state != ST_IDLE);
  assign push_req = (state == ST_RECORD) && obs && !dup;
  // A pop in the same cycle frees the slot the push needs.
  assign push     = push_req && (!full || pop);
  assign busy     = (state != ST_IDLE);

`ifdef CONC_TRACE_DEDUP_EN
  logic [DATA_W-1:0] last_out;
  logic              hist_valid;

  assign dup = hist_valid && (dut_out == last_out);

  // History follows accepted pushes only; dropped samples leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_out   <= '0;
      hist_valid <= 1'b0;
    end else if (clr) begin
      hist_valid <= 1'b0;
    end else if (push) begin
      last_out   <= dut_out;
      hist_valid <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state    <= ST_RECORD;
            overflow <= 1'b0;
          end
        end
        ST_RECORD: begin
          if (push_req && !push) overflow <= 1'b1;
          if (stop) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (count == '0) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  conc_trace_fifo #(
    .WIDTH (entry_w(PC_W, DATA_W)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata ({pc, dut_out}),
    .rdata (rd_data),
    .count (count),
    .full  (full)
  );

endmodule
